vga_scanout: RTL and testbench

// - Read side of the pixel FIFO filled by the display plane. Pops one 1-bit pixel per active

---
 rtl/vga_scanout_if.sv | 37 +++
 rtl/vga_scanout.sv | 139 +++++++++++++
 tb/tb_vga_scanout.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Pixel FIFO read port and VGA DAC outputs of the scanout block.
// master = scanout side, slave = FIFO/DAC environment.
interface vga_scanout_if;
    logic [1:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        hsync;
    logic        vsync;
    logic [11:0] vga_rgb;
    logic        synced;
    logic        frame_start;
    logic        underflow;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output hsync,
        output vsync,
        output vga_rgb,
        output synced,
        output frame_start,
        output underflow
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  hsync,
        input  vsync,
        input  vga_rgb,
        input  synced,
        input  frame_start,
        input  underflow
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: pops 1-bit pixels from a FWFT FIFO, aligns frames on the sof mark
// and drives registered hsync/vsync/RGB444 for the DAC.
module vga_scanout #(
    parameter int          PIX_DIV  = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input logic          clk,
    input logic          rst,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic pix_ce, active, at_origin, frame_end;
    logic head_sof, head_pix, sof_ok;
    logic run_slot, run_pop, hunt_pop;

    logic        hsync_q, vsync_q, synced_q, frame_start_q, underflow_q;
    logic [11:0] rgb_q;

    always_comb begin
        pix_ce    = (div_cnt == DW'(PIX_DIV - 1));
        active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        frame_end = (int'(h_cnt) == H_TOTAL - 1) && (int'(v_cnt) == V_TOTAL - 1);
        head_sof  = bus.fifo_dout[1];
        head_pix  = bus.fifo_dout[0];
        // sof must appear exactly on pixel (0,0) and nowhere else
        sof_ok    = (head_sof == at_origin);
        run_slot  = (state == RUN) && pix_ce && active;
        run_pop   = run_slot && !bus.fifo_empty && sof_ok;
        hunt_pop  = (state == HUNT) && !bus.fifo_empty && !head_sof;
    end

    assign bus.fifo_rd_en  = !rst && (run_pop || hunt_pop);
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.vga_rgb     = rgb_q;
    assign bus.synced      = synced_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underflow   = underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
            if (int'(h_cnt) == H_TOTAL - 1) begin
                h_cnt <= '0;
                if (int'(v_cnt) == V_TOTAL - 1) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= BG_COLOR;
            synced_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state)
                HUNT: begin
                    if (!bus.fifo_empty && head_sof) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (pix_ce && frame_end) begin
                        state    <= RUN;
                        synced_q <= 1'b1;
                    end
                end
                RUN: begin
                    // a refused active slot is either an underflow or a misaligned sof
                    if (run_slot && !run_pop) begin
                        state    <= HUNT;
                        synced_q <= 1'b0;
                        if (bus.fifo_empty) begin
                            underflow_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= HUNT;
                    synced_q <= 1'b0;
                end
            endcase

            if (pix_ce) begin
                hsync_q       <= !((int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END));
                vsync_q       <= !((int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END));
                rgb_q         <= (run_pop && head_pix) ? FG_COLOR : BG_COLOR;
                frame_start_q <= run_pop && at_origin;
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunk raster: FIFO model, per-cycle reference
// computed from absolute cycle count, plus scenario checks with literal expectations.
module tb_vga_scanout;
    localparam int PD  = 2;
    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HB  = 2;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int FW  = HA * VA;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
    localparam int M_HUNT = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_scanout_if bus ();

    vga_scanout #(
        .PIX_DIV (PD),  .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA),  .V_FP(VF),     .V_SYNC(VSY), .V_BP(VB),
        .FG_COLOR(FG),  .BG_COLOR(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO / writer environment
    logic [1:0] q[$];
    logic force_empty = 1'b0;
    logic pat_rand    = 1'b0;
    logic inject_req  = 1'b0;
    logic inject_done = 1'b0;
    int   junk_left   = 37;
    int   wi          = 0;
    int   pops_total  = 0;
    logic pop_req     = 1'b0;

    always @(posedge clk) begin
        #1;
        if (pop_req && q.size() > 0) begin
            void'(q.pop_front());
            pops_total++;
        end
        #2;
        while (junk_left > 0) begin
            q.push_back({1'b0, 1'($urandom % 2)});
            junk_left--;
        end
        while (q.size() < 4) begin
            logic ws, wp;
            ws = (wi % FW == 0);
            if (inject_req && !inject_done && (wi % FW == 28)) begin
                ws = 1'b1;
                inject_done = 1'b1;
            end
            wp = pat_rand ? 1'($urandom % 2) : (wi % 2 == 0);
            q.push_back({ws, wp});
            wi++;
        end
        #1;
        bus.fifo_empty = force_empty || (q.size() == 0);
        bus.fifo_dout  = (q.size() > 0) ? q[0] : 2'b00;
    end

    // reference model state and monitors
    int          m_state = M_HUNT;
    int          cyc     = 0;
    logic        e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_uf = 1'b0;
    logic [11:0] e_rgb = BG;
    int   abs_clk = 0;
    int   frame_pops = 0;
    logic fp_valid = 1'b0;
    int   fp_q[$];
    int   fs_count = 0;
    int   hs_run = 0, hs_low_last = 0, hs_fall = 0, hs_period = 0;
    int   vs_run = 0, vs_low_last = 0, vs_fall = 0, vs_period = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    always @(negedge clk) begin
        abs_clk++;
        if (rst) begin
            check("rst_hsync", bus.hsync, 1);
            check("rst_vsync", bus.vsync, 1);
            check("rst_rgb", bus.vga_rgb, BG);
            check("rst_rd_en", bus.fifo_rd_en, 0);
            check("rst_synced", bus.synced, 0);
            check("rst_frame_start", bus.frame_start, 0);
            check("rst_underflow", bus.underflow, 0);
            m_state = M_HUNT; cyc = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = BG; e_fs = 1'b0; e_uf = 1'b0;
            pop_req = 1'b0; fp_valid = 1'b0; frame_pops = 0;
        end else begin
            int   p, h, v, nxt;
            logic ce, act, org, emp, hsof, hpix, good, exp_rd;
            check("hsync", bus.hsync, e_hs);
            check("vsync", bus.vsync, e_vs);
            check("vga_rgb", bus.vga_rgb, e_rgb);
            check("frame_start", bus.frame_start, e_fs);
            check("underflow", bus.underflow, e_uf);
            check("synced", bus.synced, m_state == M_RUN);

            p    = cyc / PD;
            h    = p % HT;
            v    = (p / HT) % VT;
            ce   = (cyc % PD) == PD - 1;
            act  = (h < HA) && (v < VA);
            org  = (h == 0) && (v == 0);
            emp  = force_empty || (q.size() == 0);
            hsof = !emp && q[0][1];
            hpix = !emp && q[0][0];
            exp_rd = 1'b0; good = 1'b0; nxt = m_state;
            case (m_state)
                M_HUNT: begin
                    if (!emp && !hsof) exp_rd = 1'b1;
                    if (!emp && hsof) nxt = M_WAIT;
                end
                M_WAIT: begin
                    if (ce && h == HT - 1 && v == VT - 1) nxt = M_RUN;
                end
                default: begin
                    if (ce && act) begin
                        if (emp) begin
                            e_uf = 1'b1;
                            nxt  = M_HUNT;
                        end else if (hsof != org) begin
                            nxt = M_HUNT;
                        end else begin
                            good   = 1'b1;
                            exp_rd = 1'b1;
                        end
                    end
                end
            endcase
            check("fifo_rd_en", bus.fifo_rd_en, exp_rd);
            e_fs = 1'b0;
            if (ce) begin
                e_hs  = !(h >= HA + HF && h < HA + HF + HSY);
                e_vs  = !(v >= VA + VF && v < VA + VF + VSY);
                e_rgb = (good && hpix) ? FG : BG;
                e_fs  = good && org;
            end
            m_state = nxt;
            cyc++;
            pop_req = bus.fifo_rd_en;

            if (bus.frame_start) begin
                fs_count++;
                if (fp_valid) fp_q.push_back(frame_pops);
                fp_valid   = 1'b1;
                frame_pops = 0;
            end
            if (!bus.synced) fp_valid = 1'b0;
            if (bus.fifo_rd_en) frame_pops++;

            if (!bus.hsync) begin
                hs_run++;
                if (hs_prev) begin hs_period = abs_clk - hs_fall; hs_fall = abs_clk; end
            end else if (hs_run > 0) begin
                hs_low_last = hs_run; hs_run = 0;
            end
            hs_prev = bus.hsync;
            if (!bus.vsync) begin
                vs_run++;
                if (vs_prev) begin vs_period = abs_clk - vs_fall; vs_fall = abs_clk; end
            end else if (vs_run > 0) begin
                vs_low_last = vs_run; vs_run = 0;
            end
            vs_prev = bus.vsync;
        end
    end

    initial begin
        int   p0, f0, n0;
        logic got;

        // junk words ahead of the first sof are discarded, then WAIT holds sof
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        p0 = pops_total;
        repeat (60) @(posedge clk);
        #2;
        check("junk_pops", pops_total - p0, 37);
        check("wait_not_synced", bus.synced, 0);

        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = bus.frame_start;
        end
        check("first_frame_start", got, 1);
        check("first_pixel_rgb", bus.vga_rgb, FG);
        #1;
        f0 = fs_count;
        n0 = fp_q.size();
        repeat (610) @(negedge clk);
        #1;
        check("frame_starts", fs_count - f0, 2);
        check("frames_recorded", fp_q.size() - n0, 2);
        if (fp_q.size() - n0 >= 2) begin
            check("pops_frame_a", fp_q[n0], 48);
            check("pops_frame_b", fp_q[n0 + 1], 48);
        end
        check("hsync_low_clks", hs_low_last, 6);
        check("hsync_period", hs_period, 30);
        check("vsync_low_clks", vs_low_last, 60);
        check("vsync_period", vs_period, 300);
        check("stream_no_underflow", bus.underflow, 0);
        check("stream_synced", bus.synced, 1);

        // stray sof mid-frame
        pat_rand   = 1'b1;
        inject_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = !bus.synced;
        end
        check("mismatch_desync", got, 1);
        check("mismatch_no_underflow", bus.underflow, 0);
        repeat (1200) @(negedge clk);
        check("mismatch_resynced", bus.synced, 1);
        check("mismatch_underflow_still_0", bus.underflow, 0);

        // empty FIFO at pixel (3,2)
        got = 1'b0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(posedge clk);
            #2;
            got = bus.synced && ((cyc / PD) % HT == 3) && (((cyc / PD) / HT) % VT == 2);
        end
        check("uf_position_reached", got, 1);
        force_empty = 1'b1;
        repeat (PD) @(posedge clk);
        #2 force_empty = 1'b0;
        @(negedge clk);
        check("underflow_set", bus.underflow, 1);
        check("underflow_desync", bus.synced, 0);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            got = bus.synced;
        end
        check("underflow_resync", got, 1);
        check("underflow_sticky", bus.underflow, 1);

        // reset in the middle of a frame
        got = 1'b0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(posedge clk);
            #2;
            got = bus.synced && ((cyc / PD) % HT == 5) && (((cyc / PD) / HT) % VT == 3);
        end
        check("rst_position_reached", got, 1);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_underflow", bus.underflow, 0);
        check("post_rst_not_synced", bus.synced, 0);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            got = bus.synced;
        end
        check("post_rst_resync", got, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
